// File: rtl/axi_lite_uart_regs.sv
// AXI-lite register front end for the UART: TX/RX byte FIFOs, sticky overflow
// flags and the baud divisor, with independent read and write channel FSMs.
module axi_lite_uart_regs #(
    parameter int          ADDR_W    = 32,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [15:0]       baud_div
);
    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam logic [TX_PW:0] TX_FULL_CNT = (TX_PW+1)'(TX_DEPTH);
    localparam logic [RX_PW:0] RX_FULL_CNT = (RX_PW+1)'(RX_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

    wstate_e            wstate_q, wstate_d;
    rstate_e            rstate_q, rstate_d;
    logic [ADDR_W-1:2]  awaddr_q, awaddr_d;
    logic [1:0]         bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [15:0]        baud_q, baud_d;
    logic               tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [TX_PW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TX_PW:0]     tx_cnt_q, tx_cnt_d;
    logic [RX_PW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RX_PW:0]     rx_cnt_q, rx_cnt_d;
    logic [7:0]         tx_mem_q [TX_DEPTH];
    logic [7:0]         rx_mem_q [RX_DEPTH];

    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
    logic        tx_ovf_clr, rx_ovf_clr;
    logic        waddr_ok, raddr_ok;
    logic [31:0] status;
    logic        unused_bits;

    assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign status   = {26'b0, rx_ovf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full};
    assign waddr_ok = (awaddr_q[ADDR_W-1:4] == '0);
    assign raddr_ok = (ARADDR[ADDR_W-1:4] == '0);
    assign unused_bits = &{1'b0, ARADDR[1:0], AWADDR[1:0], WDATA[31:16], WSTRB[3:2]};

    always_comb begin
        wstate_d    = wstate_q;
        awaddr_d    = awaddr_q;
        bresp_d     = bresp_q;
        baud_d      = baud_q;
        tx_push_req = 1'b0;
        tx_ovf_clr  = 1'b0;
        rx_ovf_clr  = 1'b0;
        case (wstate_q)
            W_IDLE: if (AWVALID) begin
                awaddr_d = AWADDR[ADDR_W-1:2];
                wstate_d = W_DATA;
            end
            W_DATA: if (WVALID) begin
                wstate_d = W_RESP;
                bresp_d  = waddr_ok ? RESP_OKAY : RESP_SLVERR;
                if (waddr_ok) begin
                    case (awaddr_q[3:2])
                        2'd0: tx_push_req = WSTRB[0];
                        2'd2: if (WSTRB[0]) begin
                            tx_ovf_clr = WDATA[4];
                            rx_ovf_clr = WDATA[5];
                        end
                        2'd3: begin
                            if (WSTRB[0]) baud_d[7:0]  = WDATA[7:0];
                            if (WSTRB[1]) baud_d[15:8] = WDATA[15:8];
                        end
                        default: ;
                    endcase
                end
            end
            W_RESP: if (BREADY) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read data is captured at the AR handshake so it stays stable while RREADY is low.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rx_pop   = 1'b0;
        case (rstate_q)
            R_IDLE: if (ARVALID) begin
                rstate_d = R_DATA;
                rdata_d  = '0;
                rresp_d  = raddr_ok ? RESP_OKAY : RESP_SLVERR;
                if (raddr_ok) begin
                    case (ARADDR[3:2])
                        2'd1: if (rx_empty) begin
                            rdata_d = 32'h8000_0000;
                        end else begin
                            rdata_d = {24'b0, rx_mem_q[rx_rptr_q]};
                            rx_pop  = 1'b1;
                        end
                        2'd2: rdata_d = status;
                        2'd3: rdata_d = {16'b0, baud_q};
                        default: ;
                    endcase
                end
            end
            R_DATA: if (RREADY) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Full/empty come from the registered counts, so a same-cycle pop never rescues a push.
    always_comb begin
        tx_push   = tx_push_req && !tx_full;
        tx_pop    = !tx_empty && tx_ready;
        rx_push   = rx_valid && !rx_full;
        tx_wptr_d = tx_push ? tx_wptr_q + TX_PW'(1) : tx_wptr_q;
        tx_rptr_d = tx_pop  ? tx_rptr_q + TX_PW'(1) : tx_rptr_q;
        rx_wptr_d = rx_push ? rx_wptr_q + RX_PW'(1) : rx_wptr_q;
        rx_rptr_d = rx_pop  ? rx_rptr_q + RX_PW'(1) : rx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + (TX_PW+1)'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - (TX_PW+1)'(1);
            default: ;
        endcase
        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + (RX_PW+1)'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - (RX_PW+1)'(1);
            default: ;
        endcase
        tx_ovf_d = (tx_ovf_q && !tx_ovf_clr) || (tx_push_req && tx_full);
        rx_ovf_d = (rx_ovf_q && !rx_ovf_clr) || (rx_valid && rx_full);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            awaddr_q  <= '0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            baud_q    <= DIV_RESET;
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            awaddr_q  <= awaddr_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            baud_q    <= baud_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
        end
    end

    // Storage needs no reset; the pointers and counts define what is valid.
    always_ff @(posedge aclk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= WDATA[7:0];
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
    end

    assign AWREADY  = (wstate_q == W_IDLE) && !areset;
    assign WREADY   = (wstate_q == W_DATA) && !areset;
    assign ARREADY  = (rstate_q == R_IDLE) && !areset;
    assign BVALID   = (wstate_q == W_RESP);
    assign RVALID   = (rstate_q == R_DATA);
    assign BRESP    = bresp_q;
    assign RRESP    = rresp_q;
    assign RDATA    = rdata_q;
    assign tx_data  = tx_mem_q[tx_rptr_q];
    assign tx_valid = !tx_empty;
    assign baud_div = baud_q;
endmodule

// File: tb/tb_axi_lite_uart_regs.sv
// Directed bench for axi_lite_uart_regs: a table of bus transactions plus
// hand-written sequences for FIFO, overflow, backpressure and reset corners.
module tb_axi_lite_uart_regs;
    localparam int LIM = 20;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid;
    logic [15:0] baud_div;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  expResp;
        logic [31:0] expData;
    } vec_t;
    vec_t vecs[16];

    axi_lite_uart_regs dut (
        .aclk(aclk), .areset(areset),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .baud_div(baud_div)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: no handshake within %0d cycles", name, LIM);
    endtask

    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input bit pulseRx, output logic [1:0] resp);
        int n;
        resp = 2'bxx;
        @(negedge aclk);
        AWADDR = addr; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < LIM) begin @(negedge aclk); n++; end
        if (!AWREADY) begin timeoutFail("aw_handshake"); AWVALID = 1'b0; return; end
        @(negedge aclk);
        AWVALID = 1'b0; WDATA = data; WSTRB = strb; WVALID = 1'b1;
        if (pulseRx) rx_valid = 1'b1;
        n = 0;
        while (!WREADY && n < LIM) begin @(negedge aclk); n++; end
        if (!WREADY) begin timeoutFail("w_handshake"); WVALID = 1'b0; rx_valid = 1'b0; return; end
        @(negedge aclk);
        WVALID = 1'b0; rx_valid = 1'b0; BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < LIM) begin @(negedge aclk); n++; end
        if (!BVALID) begin timeoutFail("b_handshake"); BREADY = 1'b0; return; end
        resp = BRESP;
        @(negedge aclk);
        BREADY = 1'b0;
    endtask

    task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        data = 'x; resp = 2'bxx;
        @(negedge aclk);
        ARADDR = addr; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < LIM) begin @(negedge aclk); n++; end
        if (!ARREADY) begin timeoutFail("ar_handshake"); ARVALID = 1'b0; return; end
        @(negedge aclk);
        ARVALID = 1'b0; RREADY = 1'b1;
        n = 0;
        while (!RVALID && n < LIM) begin @(negedge aclk); n++; end
        if (!RVALID) begin timeoutFail("r_handshake"); RREADY = 1'b0; return; end
        data = RDATA; resp = RRESP;
        @(negedge aclk);
        RREADY = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0] d;
        logic [1:0]  r;
        if (v.isWrite) begin
            axiWrite(v.addr, v.data, v.strb, 1'b0, r);
            checkOutput($sformatf("vec%0d_bresp", idx), 32'(r), 32'(v.expResp));
        end else begin
            axiRead(v.addr, d, r);
            checkOutput($sformatf("vec%0d_rresp", idx), 32'(r), 32'(v.expResp));
            checkOutput($sformatf("vec%0d_rdata", idx), d, v.expData);
        end
    endtask

    task automatic writeExpect(input string name, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input bit pulseRx, input logic [1:0] expResp);
        logic [1:0] r;
        axiWrite(addr, data, strb, pulseRx, r);
        checkOutput(name, 32'(r), 32'(expResp));
    endtask

    task automatic readExpect(input string name, input logic [31:0] addr, input logic [31:0] expData);
        logic [31:0] d;
        logic [1:0]  r;
        axiRead(addr, d, r);
        checkOutput({name, "_rresp"}, 32'(r), 32'd0);
        checkOutput(name, d, expData);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h0000_000A};
        vecs[1]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h0000_01B2};
        vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h0000_0000};
        vecs[3]  = '{1'b1, 32'h0000_000C, 32'h0000_1234, 4'h1, 2'b00, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h0000_0134};
        vecs[5]  = '{1'b1, 32'h0000_000C, 32'h0000_ABCD, 4'h2, 2'b00, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h0000_AB34};
        vecs[7]  = '{1'b1, 32'h0000_000C, 32'hFFFF_0000, 4'hC, 2'b00, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h0000_AB34};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'h0000_0055, 4'hF, 2'b10, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b10, 32'h0000_0000};
        vecs[11] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h0000_AB34};
        vecs[12] = '{1'b1, 32'h0000_0004, 32'h0000_00FF, 4'h1, 2'b00, 32'h0};
        vecs[13] = '{1'b1, 32'h0000_0100, 32'h0000_0077, 4'h1, 2'b10, 32'h0};
        vecs[14] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h0000_000A};
        vecs[15] = '{1'b0, 32'h0000_000E, 32'h0,         4'h0, 2'b00, 32'h0000_AB34};

        areset = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

        // Reset state, including ready gating while reset is held.
        repeat (2) @(negedge aclk);
        checkOutput("rst_awready", 32'(AWREADY), 32'd0);
        checkOutput("rst_wready",  32'(WREADY),  32'd0);
        checkOutput("rst_arready", 32'(ARREADY), 32'd0);
        checkOutput("rst_bvalid",  32'(BVALID),  32'd0);
        checkOutput("rst_rvalid",  32'(RVALID),  32'd0);
        checkOutput("rst_rdata",   RDATA,        32'd0);
        checkOutput("rst_bresp",   32'(BRESP),   32'd0);
        checkOutput("rst_txvalid", 32'(tx_valid), 32'd0);
        checkOutput("rst_baud",    32'(baud_div), 32'd434);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("post_rst_awready", 32'(AWREADY), 32'd1);
        checkOutput("post_rst_arready", 32'(ARREADY), 32'd1);

        // Register map, byte lanes, address decode errors.
        for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);
        checkOutput("baud_port", 32'(baud_div), 32'h0000_AB34);

        // TX FIFO order and pops.
        writeExpect("tx41_bresp", 32'h0, 32'h41, 4'h1, 1'b0, 2'b00);
        writeExpect("tx42_bresp", 32'h0, 32'h42, 4'h1, 1'b0, 2'b00);
        @(negedge aclk);
        checkOutput("tx_head0_valid", 32'(tx_valid), 32'd1);
        checkOutput("tx_head0_data",  32'(tx_data),  32'h41);
        tx_ready = 1'b1;
        @(negedge aclk);
        checkOutput("tx_head1_valid", 32'(tx_valid), 32'd1);
        checkOutput("tx_head1_data",  32'(tx_data),  32'h42);
        @(negedge aclk);
        checkOutput("tx_drained", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        // Two received bytes wait in the RX FIFO while TX overflows.
        @(negedge aclk); rx_data = 8'h55; rx_valid = 1'b1;
        @(negedge aclk); rx_data = 8'hAA;
        @(negedge aclk); rx_valid = 1'b0;

        for (int i = 0; i < 9; i++)
            writeExpect($sformatf("txfill%0d_bresp", i), 32'h0, 32'h60 + 32'(i), 4'h1, 1'b0, 2'b00);
        readExpect("status_txovf", 32'h8, 32'h0000_0011);
        writeExpect("w1c_tx_bresp", 32'h8, 32'h10, 4'h1, 1'b0, 2'b00);
        readExpect("status_txovf_clr", 32'h8, 32'h0000_0001);

        // Drain: eight bytes in order across the pointer wrap, ninth was dropped.
        @(negedge aclk);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("drain%0d_data", i), 32'(tx_data), 32'h60 + 32'(i));
            @(negedge aclk);
        end
        checkOutput("drain_empty", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        // RXDATA read held with RREADY low: stable data, single pop.
        @(negedge aclk);
        ARADDR = 32'h4; ARVALID = 1'b1; RREADY = 1'b0;
        checkOutput("hold_arready", 32'(ARREADY), 32'd1);
        @(negedge aclk);
        ARVALID = 1'b0;
        checkOutput("hold_rvalid", 32'(RVALID), 32'd1);
        checkOutput("hold_rdata",  RDATA, 32'h0000_0055);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checkOutput($sformatf("hold%0d_rdata", i), RDATA, 32'h0000_0055);
            checkOutput($sformatf("hold%0d_rvalid", i), 32'(RVALID), 32'd1);
        end
        RREADY = 1'b1;
        @(negedge aclk);
        RREADY = 1'b0;
        checkOutput("hold_released", 32'(RVALID), 32'd0);
        readExpect("rx_second", 32'h4, 32'h0000_00AA);
        readExpect("rx_empty_read", 32'h4, 32'h8000_0000);
        readExpect("status_rx_empty", 32'h8, 32'h0000_000A);

        // RX overflow, W1C needing WSTRB[0], and set winning over a same-cycle clear.
        @(negedge aclk); rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'h10 + 8'(i);
            @(negedge aclk);
        end
        rx_valid = 1'b0;
        readExpect("status_rxovf", 32'h8, 32'h0000_0026);
        writeExpect("w1c_nostrb_bresp", 32'h8, 32'h20, 4'h2, 1'b0, 2'b00);
        readExpect("status_w1c_nostrb", 32'h8, 32'h0000_0026);
        writeExpect("w1c_collide_bresp", 32'h8, 32'h20, 4'h1, 1'b1, 2'b00);
        readExpect("status_set_wins", 32'h8, 32'h0000_0026);
        writeExpect("w1c_rx_bresp", 32'h8, 32'h20, 4'h1, 1'b0, 2'b00);
        readExpect("status_rxovf_clr", 32'h8, 32'h0000_0006);
        readExpect("rx_head_after_ovf", 32'h4, 32'h0000_0010);

        // Reset while both channels are mid-transaction.
        @(negedge aclk);
        AWADDR = 32'h0; AWVALID = 1'b1; ARADDR = 32'h8; ARVALID = 1'b1;
        @(negedge aclk);
        AWVALID = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
        WDATA = 32'h99; WSTRB = 4'h1; WVALID = 1'b1;
        @(negedge aclk);
        WVALID = 1'b0; BREADY = 1'b0;
        checkOutput("mid_bvalid",  32'(BVALID), 32'd1);
        checkOutput("mid_rvalid",  32'(RVALID), 32'd1);
        checkOutput("mid_rdata",   RDATA, 32'h0000_0002);
        checkOutput("mid_txvalid", 32'(tx_valid), 32'd1);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        checkOutput("abort_bvalid",  32'(BVALID), 32'd0);
        checkOutput("abort_rvalid",  32'(RVALID), 32'd0);
        checkOutput("abort_txvalid", 32'(tx_valid), 32'd0);
        checkOutput("abort_baud",    32'(baud_div), 32'd434);
        checkOutput("abort_rdata",   RDATA, 32'd0);
        readExpect("abort_status", 32'h8, 32'h0000_000A);
        readExpect("abort_baudreg", 32'hC, 32'h0000_01B2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
